// File: rtl/amp_pkg.sv
// amp_pkg: shared state encoding for the amplifier power sequencer
package amp_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    OFF        = 3'd0,
    EN_WAIT    = 3'd1,
    CFG        = 3'd2,
    RUN        = 3'd3,
    MUTE_DN    = 3'd4,
    FAULT_COOL = 3'd5,
    LOCKOUT    = 3'd6
  } state_e;
endpackage

// File: rtl/amp_err_filter.sv
// amp_err_filter: per-channel consecutive-low counter on active-low amp error flags
module amp_err_filter #(
  parameter int N_AMP    = 2,
  parameter int ERR_FILT = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             clr_i,
  input  logic [N_AMP-1:0] nerror_i,
  output logic             err_any_o
);
  localparam int CW = $clog2(ERR_FILT + 1);
  logic [N_AMP-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_AMP-1:0] hit;
  // count consecutive low samples, saturating; the threshold is judged on the updated count
  always_comb begin
    for (int i = 0; i < N_AMP; i++) begin
      cnt_d[i] = (clr_i || nerror_i[i]) ? '0 : (cnt_q[i] == CW'(ERR_FILT)) ? cnt_q[i] : cnt_q[i] + 1'b1;
      hit[i] = cnt_d[i] == CW'(ERR_FILT);
    end
  end
  assign err_any_o = |hit;
  // counter registers
  always_ff @(posedge clk_in) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/amp_seq_ctrl.sv
// amp_seq_ctrl: enable/config/unmute sequencer with filtered fault detection and timed retry
module amp_seq_ctrl
  import amp_pkg::*;
#(
  parameter int N_AMP     = 2,
  parameter int TIMER_W   = 16,
  parameter int T_EN      = 1000,
  parameter int T_CFG_TO  = 4000,
  parameter int T_MUTE    = 200,
  parameter int T_COOL    = 8000,
  parameter int ERR_FILT  = 4,
  parameter int RETRY_MAX = 3
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               enable_in,
  input  logic               audio_locked_in,
  input  logic               cfg_done_in,
  input  logic [N_AMP-1:0]   nerror_in,
  output logic [N_AMP-1:0]   nenable_out,
  output logic [N_AMP-1:0]   nmute_out,
  output logic               send_config_out,
  output logic               fault_out,
  output logic [2:0]         retry_cnt_out,
  output logic [STATE_W-1:0] state_out
);
  localparam logic [TIMER_W-1:0] L_EN   = TIMER_W'(T_EN - 1);
  localparam logic [TIMER_W-1:0] L_CFG  = TIMER_W'(T_CFG_TO - 1);
  localparam logic [TIMER_W-1:0] L_MUTE = TIMER_W'(T_MUTE - 1);
  localparam logic [TIMER_W-1:0] L_COOL = TIMER_W'(T_COOL - 1);
  localparam logic [2:0] R_MAX = 3'(RETRY_MAX);
  state_e state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d, load;
  logic [2:0] retry_q, retry_d;
  logic err, active, tmo;
  assign active = state_q inside {EN_WAIT, CFG, RUN};
  assign tmo = timer_q == '0;
  amp_err_filter #(.N_AMP(N_AMP), .ERR_FILT(ERR_FILT)) u_filt (
    .clk_in    (clk_in),
    .reset     (reset),
    .clr_i     (!active),
    .nerror_i  (nerror_in),
    .err_any_o (err)
  );
  // next state and retry count; fault beats shutdown beats normal progress
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      OFF: if (enable_in) state_d = EN_WAIT;
      EN_WAIT, CFG, RUN:
        if (err) state_d = FAULT_COOL;
        else if (!enable_in) state_d = MUTE_DN;
        else if (state_q == EN_WAIT && tmo) state_d = CFG;
        else if (state_q == CFG && cfg_done_in) state_d = RUN;
        else if (state_q == CFG && tmo) state_d = FAULT_COOL;
      MUTE_DN: if (tmo) state_d = OFF;
      FAULT_COOL:
        if (!enable_in) state_d = OFF;
        else if (tmo && retry_q < R_MAX) begin
          state_d = EN_WAIT;
          retry_d = retry_q + 1'b1;
        end else if (tmo) state_d = LOCKOUT;
      LOCKOUT: if (!enable_in) state_d = OFF;
      default: state_d = OFF;
    endcase
    if (state_d inside {OFF, MUTE_DN}) retry_d = '0;
  end
  // shared down-counter reloads on every state change so each wait state lasts exactly T cycles
  always_comb begin
    load = state_d == EN_WAIT ? L_EN : state_d == CFG ? L_CFG : state_d == MUTE_DN ? L_MUTE :
           state_d == FAULT_COOL ? L_COOL : '0;
    timer_d = state_d != state_q ? load : tmo ? '0 : timer_q - 1'b1;
  end
  // state, timer, retry and registered pin outputs derived from the state being entered
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q         <= OFF;
      timer_q         <= '0;
      retry_q         <= '0;
      nenable_out     <= '1;
      nmute_out       <= '0;
      send_config_out <= 1'b0;
      fault_out       <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      retry_q         <= retry_d;
      nenable_out     <= {N_AMP{state_d inside {OFF, FAULT_COOL, LOCKOUT}}};
      nmute_out       <= {N_AMP{state_q == RUN && state_d == RUN && audio_locked_in}};
      send_config_out <= state_d == CFG;
      fault_out       <= state_d inside {FAULT_COOL, LOCKOUT};
    end
  end
  assign retry_cnt_out = retry_q;
  assign state_out = state_q;
endmodule
